// File: rtl/vend_dispenser_ctrl.sv
// vend_dispenser_ctrl: keypad-driven order entry and multi-channel spiral motor control.
// A debounced 3x4 keypad selects a channel and quantity. The selected spiral is then
// rotated once per item, counting rotations from its home sensor pair, with cancel,
// jam timeout and status outputs for the LCD driver.
module vend_dispenser_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int SENS_DEB   = 16,
  parameter int MAX_QTY    = 9,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic [2:0]        coluna_in,
  input  logic [3:0]        linha_in,
  input  logic [NUM_CH-1:0] sensor1_in,
  input  logic [NUM_CH-1:0] sensor2_in,
  output logic [NUM_CH-1:0] rele_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              fault_out,
  output logic [3:0]        sel_ch_out,
  output logic [3:0]        remaining_out,
  output logic              key_valid_out,
  output logic [3:0]        key_code_out
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int SENS_W = $clog2(SENS_DEB + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [3:0] NUM_CH_L  = 4'(NUM_CH);
  localparam logic [3:0] MAX_QTY_L = 4'(MAX_QTY);

  typedef enum logic [2:0] {IDLE, GOT_CH, GOT_QTY, DISPENSE, FAULT} state_t;

  state_t            state;
  logic [1:0]        col_idx, row_idx;
  logic              col_ok, row_ok;
  logic              raw_key;
  logic [3:0]        raw_code;
  logic [4:0]        key_sample;
  logic [4:0]        last_sample;
  logic [DEB_W-1:0]  deb_cnt;
  logic              armed;
  logic              ch_a, ch_b;
  logic [NUM_CH-1:0] ch_mask;
  logic              at_home, item_done;
  logic              left_home, stop_req;
  logic [SENS_W-1:0] sens_cnt;
  logic [TMR_W-1:0]  item_tmr;
  logic              key_star, key_hash, key_digit;

  // Turn the raw column/row lines into a key code; anything but one column plus one row is no key
  always_comb begin
    col_idx  = 2'd0;
    row_idx  = 2'd0;
    col_ok   = 1'b1;
    row_ok   = 1'b1;
    raw_key  = 1'b0;
    raw_code = 4'd0;
    case (coluna_in)
      3'b100:  col_idx = 2'd0;
      3'b010:  col_idx = 2'd1;
      3'b001:  col_idx = 2'd2;
      default: col_ok  = 1'b0;
    endcase
    case (linha_in)
      4'b1000: row_idx = 2'd0;
      4'b0100: row_idx = 2'd1;
      4'b0010: row_idx = 2'd2;
      4'b0001: row_idx = 2'd3;
      default: row_ok  = 1'b0;
    endcase
    if (col_ok && row_ok) begin
      raw_key = 1'b1;
      if (row_idx != 2'd3) begin
        raw_code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
      end else begin
        case (col_idx)
          2'd0:    raw_code = 4'd10;
          2'd1:    raw_code = 4'd0;
          default: raw_code = 4'd11;
        endcase
      end
    end
  end

  assign key_sample = {raw_key, raw_code};

  // Debounce: a code must hold for DEB_CYCLES samples; a press fires only after a stable release
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      last_sample   <= 5'd0;
      deb_cnt       <= '0;
      armed         <= 1'b0;
      key_valid_out <= 1'b0;
      key_code_out  <= 4'd0;
    end else begin
      key_valid_out <= 1'b0;
      if (key_sample != last_sample) begin
        last_sample <= key_sample;
        deb_cnt     <= DEB_W'(1);
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt <= DEB_W'(DEB_CYCLES);
        if (!key_sample[4]) begin
          armed <= 1'b1;
        end else if (armed) begin
          armed         <= 1'b0;
          key_valid_out <= 1'b1;
          key_code_out  <= key_sample[3:0];
        end
      end else if (deb_cnt < DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Pick out the selected channel's sensor pair and relay bit; other channels are ignored
  always_comb begin
    ch_a    = 1'b0;
    ch_b    = 1'b0;
    ch_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch_out == 4'(i + 1)) begin
        ch_a       = sensor1_in[i];
        ch_b       = sensor2_in[i];
        ch_mask[i] = 1'b1;
      end
    end
  end

  assign at_home   = ch_a & ch_b;
  assign item_done = left_home && at_home && (sens_cnt == SENS_W'(SENS_DEB - 1));
  assign key_star  = key_valid_out && (key_code_out == 4'd10);
  assign key_hash  = key_valid_out && (key_code_out == 4'd11);
  assign key_digit = key_valid_out && (key_code_out <= 4'd9);

  // Order FSM: channel/quantity entry, per-item rotation counting, cancel and jam handling
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state         <= IDLE;
      sel_ch_out    <= 4'd0;
      remaining_out <= 4'd0;
      rele_out      <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      fault_out     <= 1'b0;
      item_tmr      <= '0;
      sens_cnt      <= '0;
      left_home     <= 1'b0;
      stop_req      <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (key_digit && key_code_out >= 4'd1 && key_code_out <= NUM_CH_L) begin
            sel_ch_out <= key_code_out;
            state      <= GOT_CH;
          end
        end
        GOT_CH: begin
          if (key_digit && key_code_out >= 4'd1 && key_code_out <= MAX_QTY_L) begin
            remaining_out <= key_code_out;
            state         <= GOT_QTY;
          end else if (key_star) begin
            sel_ch_out <= 4'd0;
            state      <= IDLE;
          end
        end
        GOT_QTY: begin
          if (key_hash) begin
            rele_out  <= ch_mask;
            busy_out  <= 1'b1;
            item_tmr  <= '0;
            sens_cnt  <= '0;
            left_home <= 1'b0;
            stop_req  <= 1'b0;
            state     <= DISPENSE;
          end else if (key_star) begin
            sel_ch_out    <= 4'd0;
            remaining_out <= 4'd0;
            state         <= IDLE;
          end
        end
        DISPENSE: begin
          if (key_star) begin
            stop_req <= 1'b1;
          end
          if (item_done) begin
            item_tmr  <= '0;
            sens_cnt  <= '0;
            left_home <= 1'b0;
            if (remaining_out == 4'd1 || stop_req) begin
              remaining_out <= 4'd0;
              rele_out      <= '0;
              busy_out      <= 1'b0;
              done_out      <= 1'b1;
              sel_ch_out    <= 4'd0;
              stop_req      <= 1'b0;
              state         <= IDLE;
            end else begin
              remaining_out <= remaining_out - 4'd1;
            end
          end else if (item_tmr == TMR_W'(TIMEOUT - 1)) begin
            rele_out  <= '0;
            busy_out  <= 1'b0;
            fault_out <= 1'b1;
            stop_req  <= 1'b0;
            state     <= FAULT;
          end else begin
            item_tmr <= item_tmr + TMR_W'(1);
            if (!left_home) begin
              sens_cnt <= '0;
              if (!at_home) begin
                left_home <= 1'b1;
              end
            end else if (at_home) begin
              sens_cnt <= sens_cnt + SENS_W'(1);
            end else begin
              sens_cnt <= '0;
            end
          end
        end
        FAULT: begin
          if (key_star) begin
            fault_out     <= 1'b0;
            sel_ch_out    <= 4'd0;
            remaining_out <= 4'd0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispenser_ctrl.sv
// tb_vend_dispenser_ctrl: randomized order traffic against an event-level reference model.
// Stimulus tasks push the expected observable events (key, channel, remaining, done, fault)
// into a queue; an independent monitor pops and compares whenever the DUT shows an event.
module tb_vend_dispenser_ctrl;

  localparam int NUM_CH     = 4;
  localparam int DEB_CYCLES = 16;
  localparam int SENS_DEB   = 16;
  localparam int MAX_QTY    = 9;
  localparam int TIMEOUT    = 4096;

  localparam logic [2:0] EV_KEY   = 3'd0;
  localparam logic [2:0] EV_SEL   = 3'd1;
  localparam logic [2:0] EV_REM   = 3'd2;
  localparam logic [2:0] EV_DONE  = 3'd3;
  localparam logic [2:0] EV_FAULT = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] val;
  } ev_t;

  logic              clock_in = 1'b0;
  logic              reset_in = 1'b0;
  logic [2:0]        coluna_in = 3'b000;
  logic [3:0]        linha_in = 4'b0000;
  logic [NUM_CH-1:0] sensor1_in, sensor2_in;
  logic [NUM_CH-1:0] drv1 = '1, drv2 = '1, noise1 = '1, noise2 = '1, sel_mask = '0;
  logic [NUM_CH-1:0] rele_out;
  logic              busy_out, done_out, fault_out, key_valid_out;
  logic [3:0]        sel_ch_out, remaining_out, key_code_out;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;
  bit  armed = 1'b0;
  int  m_mode = 0;
  int  m_ch = 0;
  int  m_qty = 0;

  assign sensor1_in = (sel_mask & drv1) | (~sel_mask & noise1);
  assign sensor2_in = (sel_mask & drv2) | (~sel_mask & noise2);

  vend_dispenser_ctrl #(
    .NUM_CH(NUM_CH), .DEB_CYCLES(DEB_CYCLES), .SENS_DEB(SENS_DEB),
    .MAX_QTY(MAX_QTY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock_in(clock_in), .reset_in(reset_in),
    .coluna_in(coluna_in), .linha_in(linha_in),
    .sensor1_in(sensor1_in), .sensor2_in(sensor2_in),
    .rele_out(rele_out), .busy_out(busy_out), .done_out(done_out), .fault_out(fault_out),
    .sel_ch_out(sel_ch_out), .remaining_out(remaining_out),
    .key_valid_out(key_valid_out), .key_code_out(key_code_out)
  );

  always #5 clock_in = ~clock_in;

  // Unselected channels see random sensor noise, which the DUT must ignore
  initial begin
    forever begin
      @(posedge clock_in);
      #2;
      noise1 = NUM_CH'($urandom);
      noise2 = NUM_CH'($urandom);
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required self-finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input logic [3:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic expectEvent(input logic [2:0] k, input logic [3:0] v);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_event: got kind=%0d val=%0d required no event", k, v);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v) begin
        bad++;
        $display("[TB] FAIL event: got kind=%0d val=%0d required kind=%0d val=%0d",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every observable change is matched against the head of the expectation queue
  initial begin
    logic [3:0] prev_sel, prev_rem;
    logic       prev_fault;
    prev_sel = 4'd0;
    prev_rem = 4'd0;
    prev_fault = 1'b0;
    forever begin
      @(negedge clock_in);
      if (mon_en) begin
        if (key_valid_out) expectEvent(EV_KEY, key_code_out);
        if (sel_ch_out != prev_sel) expectEvent(EV_SEL, sel_ch_out);
        if (remaining_out != prev_rem) expectEvent(EV_REM, remaining_out);
        if (done_out) begin
          expectEvent(EV_DONE, 4'd0);
          checkOutput("relay_off_at_done", int'(rele_out), 0);
          checkOutput("busy_off_at_done", int'(busy_out), 0);
        end
        if (fault_out && !prev_fault) begin
          expectEvent(EV_FAULT, remaining_out);
          checkOutput("relay_off_at_fault", int'(rele_out), 0);
        end
      end
      prev_sel = sel_ch_out;
      prev_rem = remaining_out;
      prev_fault = fault_out;
    end
  end

  task automatic waitDrain(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain_%s: got %0d pending events required 0", name, sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [6:0] keyPins(input int code);
    logic [2:0] c;
    logic [3:0] r;
    int row, col;
    if (code >= 1 && code <= 9) begin
      row = (code - 1) / 3;
      col = (code - 1) % 3;
    end else begin
      row = 3;
      col = (code == 10) ? 0 : (code == 0) ? 1 : 2;
    end
    c = 3'b100;
    r = 4'b1000;
    c = c >> col;
    r = r >> row;
    return {c, r};
  endfunction

  task automatic holdPins(input logic [2:0] c, input logic [3:0] r, input int n);
    coluna_in = c;
    linha_in  = r;
    tick(n);
  endtask

  task automatic pressKey(input int code, input int hold, input int rel);
    logic [6:0] p;
    p = keyPins(code);
    holdPins(p[6:4], p[3:0], hold);
    holdPins(3'b000, 4'b0000, rel);
  endtask

  // Reference model of order entry, expressed as the events each accepted key should cause
  task automatic modelKey(input int code);
    push(EV_KEY, 4'(code));
    case (m_mode)
      0: if (code >= 1 && code <= NUM_CH) begin
           m_ch = code; push(EV_SEL, 4'(code)); m_mode = 1;
         end
      1: if (code >= 1 && code <= MAX_QTY) begin
           m_qty = code; push(EV_REM, 4'(code)); m_mode = 2;
         end else if (code == 10) begin
           m_ch = 0; push(EV_SEL, 4'd0); m_mode = 0;
         end
      2: if (code == 11) begin
           m_mode = 3;
         end else if (code == 10) begin
           m_ch = 0; m_qty = 0; push(EV_SEL, 4'd0); push(EV_REM, 4'd0); m_mode = 0;
         end
      4: if (code == 10) begin
           m_ch = 0; m_qty = 0; push(EV_SEL, 4'd0); push(EV_REM, 4'd0); m_mode = 0;
         end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input int code, input int hold);
    if (hold >= DEB_CYCLES && armed) modelKey(code);
    pressKey(code, hold, 20);
    armed = 1'b1;
  endtask

  task automatic rotate(input int away, input int glitch, input int home);
    for (int i = 0; i < away; i++) begin
      int p;
      p = $urandom_range(0, 2);
      drv1 = (p == 2) ? '1 : '0;
      drv2 = (p == 1) ? '1 : '0;
      tick(1);
    end
    if (glitch > 0) begin
      drv1 = '1; drv2 = '1;
      tick(glitch);
      drv1 = '0; drv2 = '0;
      tick(4);
    end
    drv1 = '1; drv2 = '1;
    tick(home);
  endtask

  task automatic runOrder(input int ch, input int qty, input int cancel_at,
                          input int jam_at, input bit directed);
    sel_mask = NUM_CH'(1 << (ch - 1));
    applyStimulus(ch, 20);
    applyStimulus(qty, 20);
    applyStimulus(11, 20);
    waitDrain(100, "entry");
    checkOutput("busy_on", int'(busy_out), 1);
    checkOutput("relay_on", int'(rele_out), 1 << (ch - 1));
    checkOutput("sel_ch", int'(sel_ch_out), ch);
    checkOutput("remaining_start", int'(remaining_out), qty);
    for (int i = 1; i <= qty; i++) begin
      int  away, glitch, home, xkey;
      bit  extra;
      if (i == jam_at) begin
        m_mode = 4;
        push(EV_FAULT, 4'(qty - i + 1));
        waitDrain(TIMEOUT + 100, "jam");
        checkOutput("fault_on", int'(fault_out), 1);
        checkOutput("relay_off_jam", int'(rele_out), 0);
        checkOutput("remaining_held", int'(remaining_out), qty - i + 1);
        applyStimulus(10, 20);
        waitDrain(100, "fault_clear");
        checkOutput("fault_cleared", int'(fault_out), 0);
        checkOutput("sel_cleared", int'(sel_ch_out), 0);
        checkOutput("remaining_cleared", int'(remaining_out), 0);
        return;
      end
      if (i == cancel_at) begin
        push(EV_KEY, 4'd10);
        push(EV_SEL, 4'd0);
        push(EV_REM, 4'd0);
        push(EV_DONE, 4'd0);
        fork
          rotate(80, 0, 25);
          pressKey(10, 20, 20);
        join
        m_mode = 0; m_ch = 0; m_qty = 0;
        waitDrain(100, "cancel");
        checkOutput("relay_off_cancel", int'(rele_out), 0);
        checkOutput("busy_off_cancel", int'(busy_out), 0);
        return;
      end
      extra = !directed && ($urandom_range(0, 3) == 0);
      xkey = ($urandom_range(0, 1) == 1) ? 11 : int'($urandom_range(0, 9));
      if (extra) push(EV_KEY, 4'(xkey));
      if (i == qty) begin
        push(EV_SEL, 4'd0);
        push(EV_REM, 4'd0);
        push(EV_DONE, 4'd0);
      end else begin
        push(EV_REM, 4'(qty - i));
      end
      away   = directed ? 40 : int'($urandom_range(45, 70));
      glitch = (!directed && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, SENS_DEB - 2)) : 0;
      home   = directed ? 20 : int'($urandom_range(SENS_DEB + 2, 30));
      fork
        rotate(away, glitch, home);
        begin
          if (extra) pressKey(xkey, 20, 20);
        end
      join
    end
    m_mode = 0; m_ch = 0; m_qty = 0;
    waitDrain(100, "done");
    checkOutput("relay_off_end", int'(rele_out), 0);
    checkOutput("sel_end", int'(sel_ch_out), 0);
    checkOutput("busy_end", int'(busy_out), 0);
  endtask

  // Main sequence: reset, debounce, entry rules, directed orders, reset mid-order, random orders
  initial begin
    int ch, qty, cancel_at;
    tick(3);
    checkOutput("reset_relay", int'(rele_out), 0);
    checkOutput("reset_busy", int'(busy_out), 0);
    checkOutput("reset_sel", int'(sel_ch_out), 0);
    checkOutput("reset_remaining", int'(remaining_out), 0);
    checkOutput("reset_key_valid", int'(key_valid_out), 0);
    reset_in = 1'b1;
    tick(2);
    mon_en = 1'b1;
    holdPins(3'b000, 4'b0000, 20);
    armed = 1'b1;

    $display("[TB] debounce");
    pressKey(5, 10, 20);
    applyStimulus(5, 20);
    holdPins(3'b110, 4'b0100, 25);
    holdPins(3'b000, 4'b0000, 20);
    holdPins(3'b010, 4'b0110, 25);
    holdPins(3'b000, 4'b0000, 20);
    waitDrain(50, "debounce");
    checkOutput("key_code_5", int'(key_code_out), 5);

    $display("[TB] invalid entry");
    applyStimulus(7, 20);
    waitDrain(50, "key7");
    checkOutput("sel_after_7", int'(sel_ch_out), 0);
    applyStimulus(1, 20);
    applyStimulus(11, 20);
    waitDrain(50, "hash_in_got_ch");
    checkOutput("sel_after_hash", int'(sel_ch_out), 1);
    checkOutput("busy_after_hash", int'(busy_out), 0);
    applyStimulus(10, 20);
    applyStimulus(2, 20);
    applyStimulus(4, 20);
    applyStimulus(10, 20);
    waitDrain(50, "qty_cancel");
    checkOutput("remaining_after_cancel", int'(remaining_out), 0);

    $display("[TB] directed orders");
    runOrder(2, 3, 0, 0, 1'b1);
    runOrder(1, 5, 2, 0, 1'b1);
    runOrder(3, 2, 0, 1, 1'b1);

    $display("[TB] reset mid-dispense");
    sel_mask = 4'b1000;
    applyStimulus(4, 20);
    applyStimulus(2, 20);
    applyStimulus(11, 20);
    waitDrain(50, "pre_reset");
    drv1 = '0; drv2 = '0;
    tick(10);
    mon_en = 1'b0;
    reset_in = 1'b0;
    coluna_in = 3'b010;
    linha_in = 4'b0100;
    #2;
    checkOutput("async_relay", int'(rele_out), 0);
    checkOutput("async_busy", int'(busy_out), 0);
    checkOutput("async_sel", int'(sel_ch_out), 0);
    checkOutput("async_remaining", int'(remaining_out), 0);
    checkOutput("async_fault", int'(fault_out), 0);
    checkOutput("async_done", int'(done_out), 0);
    checkOutput("async_key_code", int'(key_code_out), 0);
    sb.delete();
    m_mode = 0; m_ch = 0; m_qty = 0;
    armed = 1'b0;
    drv1 = '1; drv2 = '1;
    tick(3);
    reset_in = 1'b1;
    tick(2);
    mon_en = 1'b1;
    tick(30);
    holdPins(3'b000, 4'b0000, 20);
    armed = 1'b1;
    applyStimulus(5, 20);
    waitDrain(50, "post_reset_key");
    checkOutput("post_reset_sel", int'(sel_ch_out), 0);

    $display("[TB] random orders");
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int junk;
        junk = ($urandom_range(0, 1) == 1) ? 11 : int'($urandom_range(5, 9));
        applyStimulus(junk, 20);
      end
      if ($urandom_range(0, 2) == 0) applyStimulus(int'($urandom_range(1, 9)), int'($urandom_range(4, 12)));
      ch = $urandom_range(1, NUM_CH);
      qty = $urandom_range(1, 4);
      cancel_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, qty)) : 0;
      runOrder(ch, qty, cancel_at, 0, 1'b0);
    end

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_dispenser_ctrl.md
Name: vend_dispenser_ctrl

Overview:
Multi-channel successor to the single-relay vending controller.
- Decodes the 3x4 matrix keypad with a parametrised debounce.
- Accepts a channel digit, a quantity digit and a confirm key.
- Drives one motor relay per spiral channel, counting completed rotations from a per-channel sensor pair.
- Adds cancel, per-item jam timeout and status outputs for the LCD driver.

Parameters:
NUM_CH, 4, number of spiral channels (1..9)
DEB_CYCLES, 16, consecutive stable cycles needed for a key press or release
SENS_DEB, 16, consecutive stable cycles of sensor pair at home needed to count a rotation
MAX_QTY, 9, largest accepted quantity (1..9)
TIMEOUT, 4096, max cycles per item rotation before fault

Ports:
clock_in  input  1  system clock
reset_in  input  1  asynchronous, active-low reset
coluna_in  input  3  keypad column, one-hot (100=left, 010=mid, 001=right)
linha_in  input  4  keypad row, one-hot (1000=top .. 0001=bottom)
sensor1_in  input  NUM_CH  sensor A per channel, 1 = home/unblocked
sensor2_in  input  NUM_CH  sensor B per channel, 1 = home/unblocked
rele_out  output  NUM_CH  motor relay per channel, at most one bit high
busy_out  output  1  high in DISPENSE
done_out  output  1  one-cycle pulse when an order completes or is cancelled mid-dispense
fault_out  output  1  high in FAULT
sel_ch_out  output  4  selected channel number (0 = none)
remaining_out  output  4  items still to dispense
key_valid_out  output  1  one-cycle pulse per debounced key press
key_code_out  output  4  last key: 0-9, 10='*', 11='#'

Behaviour:
Reset (reset_in=0, asynchronous):
- All outputs 0; state IDLE; all counters and timers 0.

Key decode:
- Rows 1000/0100/0010 with columns 100/010/001 give keys 1-3, 4-6, 7-9.
- Row 0001 gives '*' (col 100), '0' (col 010), '#' (col 001).
- Any input that is not exactly one column bit plus one row bit is "no key".

Debounce:
- A key code must be stable for DEB_CYCLES consecutive cycles to be accepted.
- On acceptance: key_valid_out pulses for 1 cycle on the following edge and key_code_out updates.
- No further press event until "no key" has been stable for DEB_CYCLES cycles (held key = single event).
- A code change restarts the stability count.

FSM:
- IDLE, digit d with 1<=d<=NUM_CH: sel_ch_out=d, go to GOT_CH. Other keys ignored.
- GOT_CH, digit q with 1<=q<=MAX_QTY: remaining_out=q, go to GOT_QTY. '*' clears sel_ch_out, go to IDLE. Others ignored.
- GOT_QTY, '#': go to DISPENSE. '*': clear sel_ch_out and remaining_out, go to IDLE. Others ignored.
- DISPENSE:
  - rele_out[sel_ch_out-1]=1; per-item timer runs.
  - The item phase first waits for the channel's sensor pair to leave home (either sensor 0).
  - It then waits for both sensors =1 for SENS_DEB consecutive cycles. At that point remaining_out decrements and the timer clears.
  - remaining_out reaching 0: relay off the same edge, done_out pulse, clear sel_ch_out, go to IDLE.
  - '*' during DISPENSE sets a stop flag. After the current item completes, remaining_out is forced to 0, done_out pulses and the FSM goes to IDLE. No abrupt mid-rotation stop.
  - Timer reaching TIMEOUT before an item completes: relay off, fault_out=1, go to FAULT. remaining_out is held so the shortfall stays visible.
- FAULT:
  - All relays 0; only '*' is accepted.
  - '*' clears fault_out, sel_ch_out and remaining_out, then goes to IDLE.

Boundaries:
- Sensors of non-selected channels are ignored.
- A sensor glitch shorter than SENS_DEB at home does not count.
- A timeout and an item completion on the same edge: completion wins.
- Keypad events other than '*' are ignored in DISPENSE.
- The timer width must hold TIMEOUT without wrap.

Test Plan:
- Reset: drive reset_in=0 mid-DISPENSE -> all outputs 0 immediately. Release -> IDLE; a held key gives no event until it is released and pressed again.
- Debounce: key 5 (col 010, row 0100) held 10 cycles, then held 20 cycles (DEB_CYCLES=16) -> no pulse for the 10-cycle press. Exactly one key_valid_out pulse with key_code_out=5 for the 20-cycle press.
- Normal order: keys 2, 3, '#' then 3 sensor rotations (leave home 40 cycles, home 20 cycles) -> rele_out=0010, remaining_out 3->2->1->0, done_out pulse, rele_out=0000, sel_ch_out=0.
- Invalid entry: key 7 with NUM_CH=4 -> stays IDLE, sel_ch_out=0. Keys 1, '#' -> '#' ignored in GOT_CH.
- Cancel mid-dispense: keys 1, 5, '#', then '*' during item 2 -> item 2 completes, remaining_out forced 0, done_out pulse, relay off.
- Jam: keys 3, 2, '#' with sensors held at home -> after TIMEOUT cycles fault_out=1, rele_out=0, remaining_out=2. '*' -> IDLE, all cleared.
